// File: rtl/hash_resp_collector.sv
// Response collector: FWFT FIFO that splits hash-table response words into data and flags.
// Optional saturating per-flag counters are built when HASH_RESP_COUNTERS_EN is defined.
module hash_resp_collector #(
  parameter int DATA_WIDTH = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   resp_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [3:0]                    flags_o,
  output logic                          any_error_o,
  output logic                          valid_o,
  input  logic                          ready_i,
`ifdef HASH_RESP_COUNTERS_EN
  input  logic                          cnt_clear_i,
  output logic [CNT_WIDTH-1:0]          cnt_key_present_o,
  output logic [CNT_WIDTH-1:0]          cnt_not_found_o,
  output logic [CNT_WIDTH-1:0]          cnt_no_space_o,
  output logic [CNT_WIDTH-1:0]          cnt_no_del_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_WIDTH + 4;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_live;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // r_live holds ready_o low until the first edge after reset release
  assign ready_o     = r_live && (r_level < LW'(FIFO_DEPTH));
  assign valid_o     = (r_level != '0);
  assign w_push      = valid_i && ready_o;
  assign w_pop       = valid_o && ready_i;
  assign w_head      = r_mem[r_rptr];
  assign data_o      = valid_o ? w_head[DATA_WIDTH-1:0] : '0;
  assign flags_o     = valid_o ? w_head[EW-1 -: 4] : 4'b0000;
  assign any_error_o = |flags_o;
  assign level_o     = r_level;

  generate
    if (DATA_WIDTH < 28) begin : g_drop
      logic w_unused_bits;
      assign w_unused_bits = ^resp_i[27:DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {resp_i[31:28], resp_i[DATA_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef HASH_RESP_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cnt [4];

  // index follows flags_o bit position; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (cnt_clear_i) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_pop) begin
      for (int i = 0; i < 4; i++) begin
        if (flags_o[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign cnt_key_present_o = r_cnt[3];
  assign cnt_not_found_o   = r_cnt[2];
  assign cnt_no_space_o    = r_cnt[1];
  assign cnt_no_del_o      = r_cnt[0];
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_hash_resp_collector.sv
// Scoreboard bench for hash_resp_collector: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_hash_resp_collector;
  localparam int DW    = 25;
  localparam int DEPTH = 4;
`ifdef HASH_RESP_COUNTERS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   resp_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic [3:0]    flags_o;
  logic          any_error_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [2:0]    level_o;
`ifdef HASH_RESP_COUNTERS_EN
  logic          cnt_clear_i = 1'b0;
  logic [CW-1:0] cnt_key_present_o, cnt_not_found_o, cnt_no_space_o, cnt_no_del_o;
  int            m_cnt [4];
`endif

  hash_resp_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .resp_i(resp_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .flags_o(flags_o), .any_error_o(any_error_o), .valid_o(valid_o),
    .ready_i(ready_i),
`ifdef HASH_RESP_COUNTERS_EN
    .cnt_clear_i(cnt_clear_i), .cnt_key_present_o(cnt_key_present_o),
    .cnt_not_found_o(cnt_not_found_o), .cnt_no_space_o(cnt_no_space_o),
    .cnt_no_del_o(cnt_no_del_o),
`endif
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb [$];
  int          m_level = 0;
  bit          m_live = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over its head word.
  always @(negedge clk) begin
    logic [31:0] w;
    if (reset) begin
`ifdef HASH_RESP_COUNTERS_EN
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
    end else begin
`ifdef HASH_RESP_COUNTERS_EN
      chk("cnt_key_present", 32'(cnt_key_present_o), 32'(m_cnt[3]));
      chk("cnt_not_found",   32'(cnt_not_found_o),   32'(m_cnt[2]));
      chk("cnt_no_space",    32'(cnt_no_space_o),    32'(m_cnt[1]));
      chk("cnt_no_del",      32'(cnt_no_del_o),      32'(m_cnt[0]));
`endif
      w = '0;
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 32'(valid_o), 32'd0);
        end else begin
          w = sb.pop_front();
          chk("data", 32'(data_o), 32'(w[DW-1:0]));
          chk("flags", 32'(flags_o), 32'(w[31:28]));
          chk("any_error", 32'(any_error_o), 32'(w[31:28] != 4'b0000));
        end
      end
`ifdef HASH_RESP_COUNTERS_EN
      if (cnt_clear_i) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (w[28+i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      end
`endif
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input bit v, input logic [31:0] w, input bit r, output bit acc);
    bit exp_rdy;
    bit pop;
    valid_i = v;
    resp_i  = w;
    ready_i = r;
    @(negedge clk);
    exp_rdy = m_live && (m_level < DEPTH);
    chk("level", 32'(level_o), 32'(m_level));
    chk("ready", 32'(ready_o), 32'(exp_rdy));
    chk("valid", 32'(valid_o), 32'(m_level != 0));
    if (m_level == 0) chk("idle_head", {3'b0, data_o, flags_o}, 32'd0);
    acc = v && exp_rdy;
    pop = r && (m_level != 0);
    if (acc) sb.push_back(w);
    m_level = m_level + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
    if (!reset) m_live = 1;
  endtask

  task automatic drain();
    bit a;
    repeat (DEPTH + 2) step(0, '0, 1, a);
  endtask

  initial begin
    bit          a;
    logic [31:0] w5;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_head", {3'b0, data_o, flags_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic FWFT latency
    step(0, '0, 0, a);
    step(1, 32'h0000_0ABC, 1, a);
    step(0, '0, 1, a);

    // overfill then drain; the fifth word waits for space
    for (int i = 0; i < 4; i++) step(1, 32'h0100_0000 + i, 0, a);
    w5 = 32'h0100_0004;
    step(1, w5, 0, a);
    chk("fifth_rejected", 32'(a), 32'd0);
    a = 0;
    for (int t = 0; t < 4 && !a; t++) step(1, w5, 1, a);
    chk("fifth_accepted", 32'(a), 32'd1);
    drain();

    // flag splitting
    step(1, 32'h8000_0000, 0, a);
    step(1, 32'h7000_0001, 0, a);
    drain();

    // steady push+pop at level 2 across pointer wrap
    step(1, $urandom, 0, a);
    step(1, $urandom, 0, a);
    repeat (100) step(1, $urandom, 1, a);
    drain();

`ifdef HASH_RESP_COUNTERS_EN
    for (int i = 0; i < 5; i++) step(1, 32'h4000_0000 + i, 1, a);
    drain();
    chk("not_found_sat", 32'(cnt_not_found_o), 32'd3);
    step(1, 32'h4000_0010, 0, a);
    cnt_clear_i = 1'b1;
    step(0, '0, 1, a);
    cnt_clear_i = 1'b0;
    step(0, '0, 0, a);
    chk("clear_wins", 32'(cnt_not_found_o), 32'd0);
`endif

    // random traffic
    repeat (400) step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), a);
    drain();

    // asynchronous reset with words in flight
    for (int i = 0; i < 3; i++) step(1, 32'hF000_0000 + i, 0, a);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd0);
    sb.delete();
    m_level = 0;
    m_live  = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, '0, 1, a);
    step(0, '0, 1, a);
    step(1, 32'h0000_1234, 1, a);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
